// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode results, squashes on flush, inserts load-use bubbles.
// Latency: one cycle from *_id inputs to *_id_ex outputs; every output comes straight from a flop.
// Backpressure: hold freezes all state (bubble counter too); a pending bubble waits until hold drops.
module id_ex_reg (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        RegWrite_id,
    input  logic        MemRead_id,
    input  logic        MemWrite_id,
    input  logic        MemToReg_id,
    input  logic        Halt_id,
    input  logic [3:0]  ALUOp_id,
    input  logic [15:0] PC2_id,
    input  logic [15:0] RdData1_id,
    input  logic [15:0] RdData2_id,
    input  logic [15:0] Imm_id,
    input  logic [2:0]  Rs_id,
    input  logic [2:0]  Rt_id,
    input  logic [2:0]  WriteReg_id,
    input  logic        RsValid_id,
    input  logic        RtValid_id,
    input  logic        Valid_id,

    input  logic        controlZero,
    input  logic        flush,
    input  logic        hold,

    output logic        RegWrite_id_ex,
    output logic        MemRead_id_ex,
    output logic        MemWrite_id_ex,
    output logic        MemToReg_id_ex,
    output logic        Halt_id_ex,
    output logic [3:0]  ALUOp_id_ex,
    output logic [15:0] PC2_id_ex,
    output logic [15:0] RdData1_id_ex,
    output logic [15:0] RdData2_id_ex,
    output logic [15:0] Imm_id_ex,
    output logic [2:0]  Rs_id_ex,
    output logic [2:0]  Rt_id_ex,
    output logic [2:0]  WriteReg_id_ex,
    output logic        RsValid_id_ex,
    output logic        RtValid_id_ex,
    output logic        Valid_id_ex,

    output logic [15:0] bubbleCount,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_BUBBLE  = 2'b01;
    localparam logic [1:0] ST_FLUSHED = 2'b10;
    localparam logic [1:0] ST_HELD    = 2'b11;

    // Fields that a bubble or flush must zero; everything else is payload.
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       halt;
        logic [3:0] alu_op;
        logic       rs_valid;
        logic       rt_valid;
        logic       valid;
    } ctrl_t;

    typedef struct packed {
        logic [15:0] pc2;
        logic [15:0] rd_data1;
        logic [15:0] rd_data2;
        logic [15:0] imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  write_reg;
    } data_t;

    ctrl_t       ctrl_in;
    data_t       data_in;
    ctrl_t       ctrl_q;
    data_t       data_q;
    logic [15:0] bubble_count_q;
    logic [1:0]  state_q;
    logic [1:0]  next_state;

    always_comb begin
        ctrl_in.reg_write  = RegWrite_id;
        ctrl_in.mem_read   = MemRead_id;
        ctrl_in.mem_write  = MemWrite_id;
        ctrl_in.mem_to_reg = MemToReg_id;
        ctrl_in.halt       = Halt_id;
        ctrl_in.alu_op     = ALUOp_id;
        ctrl_in.rs_valid   = RsValid_id;
        ctrl_in.rt_valid   = RtValid_id;
        ctrl_in.valid      = Valid_id;
    end

    always_comb begin
        data_in.pc2       = PC2_id;
        data_in.rd_data1  = RdData1_id;
        data_in.rd_data2  = RdData2_id;
        data_in.imm       = Imm_id;
        data_in.rs        = Rs_id;
        data_in.rt        = Rt_id;
        data_in.write_reg = WriteReg_id;
    end

    // Action priority: flush beats hold beats bubble beats a plain load.
    always_comb begin
        next_state = ST_RUN;
        if (flush)
            next_state = ST_FLUSHED;
        else if (hold)
            next_state = ST_HELD;
        else if (controlZero)
            next_state = ST_BUBBLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q         <= '0;
            data_q         <= '0;
            bubble_count_q <= '0;
            state_q        <= ST_RUN;
        end else begin
            state_q <= next_state;
            case (next_state)
                ST_FLUSHED: begin
                    ctrl_q <= '0;
                    data_q <= data_in;
                end
                ST_HELD: begin
                    ctrl_q <= ctrl_q;
                    data_q <= data_q;
                end
                ST_BUBBLE: begin
                    // Payload still loads; it is meaningless while valid is low.
                    ctrl_q <= '0;
                    data_q <= data_in;
                    if (bubble_count_q != 16'hFFFF)
                        bubble_count_q <= bubble_count_q + 16'd1;
                end
                default: begin
                    ctrl_q <= ctrl_in;
                    data_q <= data_in;
                end
            endcase
        end
    end

    assign RegWrite_id_ex = ctrl_q.reg_write;
    assign MemRead_id_ex  = ctrl_q.mem_read;
    assign MemWrite_id_ex = ctrl_q.mem_write;
    assign MemToReg_id_ex = ctrl_q.mem_to_reg;
    assign Halt_id_ex     = ctrl_q.halt;
    assign ALUOp_id_ex    = ctrl_q.alu_op;
    assign RsValid_id_ex  = ctrl_q.rs_valid;
    assign RtValid_id_ex  = ctrl_q.rt_valid;
    assign Valid_id_ex    = ctrl_q.valid;

    assign PC2_id_ex      = data_q.pc2;
    assign RdData1_id_ex  = data_q.rd_data1;
    assign RdData2_id_ex  = data_q.rd_data2;
    assign Imm_id_ex      = data_q.imm;
    assign Rs_id_ex       = data_q.rs;
    assign Rt_id_ex       = data_q.rt;
    assign WriteReg_id_ex = data_q.write_reg;

    assign bubbleCount    = bubble_count_q;
    assign state          = state_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, load, bubble, flush/hold priority, saturation, reset mid-hold.
module tb_id_ex_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, Halt_id;
    logic [3:0]  ALUOp_id;
    logic [15:0] PC2_id, RdData1_id, RdData2_id, Imm_id;
    logic [2:0]  Rs_id, Rt_id, WriteReg_id;
    logic        RsValid_id, RtValid_id, Valid_id;
    logic        controlZero, flush, hold;

    logic        RegWrite_id_ex, MemRead_id_ex, MemWrite_id_ex, MemToReg_id_ex, Halt_id_ex;
    logic [3:0]  ALUOp_id_ex;
    logic [15:0] PC2_id_ex, RdData1_id_ex, RdData2_id_ex, Imm_id_ex;
    logic [2:0]  Rs_id_ex, Rt_id_ex, WriteReg_id_ex;
    logic        RsValid_id_ex, RtValid_id_ex, Valid_id_ex;
    logic [15:0] bubbleCount;
    logic [1:0]  state;

    int vectors_applied = 0;
    int miscompares     = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .MemWrite_id(MemWrite_id),
        .MemToReg_id(MemToReg_id), .Halt_id(Halt_id), .ALUOp_id(ALUOp_id),
        .PC2_id(PC2_id), .RdData1_id(RdData1_id), .RdData2_id(RdData2_id), .Imm_id(Imm_id),
        .Rs_id(Rs_id), .Rt_id(Rt_id), .WriteReg_id(WriteReg_id),
        .RsValid_id(RsValid_id), .RtValid_id(RtValid_id), .Valid_id(Valid_id),
        .controlZero(controlZero), .flush(flush), .hold(hold),
        .RegWrite_id_ex(RegWrite_id_ex), .MemRead_id_ex(MemRead_id_ex),
        .MemWrite_id_ex(MemWrite_id_ex), .MemToReg_id_ex(MemToReg_id_ex),
        .Halt_id_ex(Halt_id_ex), .ALUOp_id_ex(ALUOp_id_ex),
        .PC2_id_ex(PC2_id_ex), .RdData1_id_ex(RdData1_id_ex), .RdData2_id_ex(RdData2_id_ex),
        .Imm_id_ex(Imm_id_ex), .Rs_id_ex(Rs_id_ex), .Rt_id_ex(Rt_id_ex),
        .WriteReg_id_ex(WriteReg_id_ex), .RsValid_id_ex(RsValid_id_ex),
        .RtValid_id_ex(RtValid_id_ex), .Valid_id_ex(Valid_id_ex),
        .bubbleCount(bubbleCount), .state(state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWrite_id = 0; MemRead_id = 0; MemWrite_id = 0; MemToReg_id = 0; Halt_id = 0;
        ALUOp_id = 4'h0; PC2_id = 16'h0; RdData1_id = 16'h0; RdData2_id = 16'h0; Imm_id = 16'h0;
        Rs_id = 3'd0; Rt_id = 3'd0; WriteReg_id = 3'd0;
        RsValid_id = 0; RtValid_id = 0; Valid_id = 0;
        controlZero = 0; flush = 0; hold = 0;
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Reset must win over a busy input set.
        RegWrite_id = 1; Valid_id = 1; Imm_id = 16'hAAAA; ALUOp_id = 4'h7;
        flush = 1; hold = 1; controlZero = 1;
        step();
        step();
        check_eq("rst_valid",   {31'd0, Valid_id_ex},    32'd0);
        check_eq("rst_regwr",   {31'd0, RegWrite_id_ex}, 32'd0);
        check_eq("rst_imm",     {16'd0, Imm_id_ex},      32'd0);
        check_eq("rst_aluop",   {28'd0, ALUOp_id_ex},    32'd0);
        check_eq("rst_count",   {16'd0, bubbleCount},    32'd0);
        check_eq("rst_state",   {30'd0, state},          32'd0);

        // Reset then load.
        clear_inputs();
        rst_n = 1'b1;
        PC2_id = 16'h0010; RdData1_id = 16'h1234; MemRead_id = 1; Rt_id = 3'd5; Valid_id = 1;
        step();
        check_eq("ld_pc2",      {16'd0, PC2_id_ex},      32'h0010);
        check_eq("ld_rd1",      {16'd0, RdData1_id_ex},  32'h1234);
        check_eq("ld_memrd",    {31'd0, MemRead_id_ex},  32'd1);
        check_eq("ld_rt",       {29'd0, Rt_id_ex},       32'd5);
        check_eq("ld_valid",    {31'd0, Valid_id_ex},    32'd1);
        check_eq("ld_state",    {30'd0, state},          32'd0);
        check_eq("ld_count",    {16'd0, bubbleCount},    32'd0);

        // Load-use bubble: control cleared, payload still loads.
        clear_inputs();
        controlZero = 1; RegWrite_id = 1; Valid_id = 1; ALUOp_id = 4'h9; PC2_id = 16'h0014;
        RdData2_id = 16'h5A5A; RsValid_id = 1;
        step();
        check_eq("bub_regwr",   {31'd0, RegWrite_id_ex}, 32'd0);
        check_eq("bub_memrd",   {31'd0, MemRead_id_ex},  32'd0);
        check_eq("bub_valid",   {31'd0, Valid_id_ex},    32'd0);
        check_eq("bub_aluop",   {28'd0, ALUOp_id_ex},    32'd0);
        check_eq("bub_rsvld",   {31'd0, RsValid_id_ex},  32'd0);
        check_eq("bub_pc2",     {16'd0, PC2_id_ex},      32'h0014);
        check_eq("bub_state",   {30'd0, state},          32'd1);
        check_eq("bub_count",   {16'd0, bubbleCount},    32'd1);
        controlZero = 0;
        step();
        check_eq("post_regwr",  {31'd0, RegWrite_id_ex}, 32'd1);
        check_eq("post_aluop",  {28'd0, ALUOp_id_ex},    32'h9);
        check_eq("post_state",  {30'd0, state},          32'd0);
        check_eq("post_count",  {16'd0, bubbleCount},    32'd1);

        // Flush together with controlZero acts as flush only.
        flush = 1; controlZero = 1;
        step();
        check_eq("fl_valid",    {31'd0, Valid_id_ex},    32'd0);
        check_eq("fl_regwr",    {31'd0, RegWrite_id_ex}, 32'd0);
        check_eq("fl_state",    {30'd0, state},          32'd2);
        check_eq("fl_count",    {16'd0, bubbleCount},    32'd1);

        // Hold with controlZero freezes everything for three cycles.
        clear_inputs();
        Imm_id = 16'hBEEF; Valid_id = 1; ALUOp_id = 4'h5; MemWrite_id = 1;
        step();
        check_eq("pre_hold_imm", {16'd0, Imm_id_ex},     32'hBEEF);
        hold = 1; controlZero = 1; Imm_id = 16'h1111; Valid_id = 0; ALUOp_id = 4'h2; MemWrite_id = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("hold_imm",   {16'd0, Imm_id_ex},      32'hBEEF);
            check_eq("hold_valid", {31'd0, Valid_id_ex},    32'd1);
            check_eq("hold_aluop", {28'd0, ALUOp_id_ex},    32'h5);
            check_eq("hold_memwr", {31'd0, MemWrite_id_ex}, 32'd1);
            check_eq("hold_state", {30'd0, state},          32'd3);
            check_eq("hold_count", {16'd0, bubbleCount},    32'd1);
        end
        hold = 0;
        step();
        check_eq("unhold_state", {30'd0, state},         32'd1);
        check_eq("unhold_count", {16'd0, bubbleCount},   32'd2);
        check_eq("unhold_valid", {31'd0, Valid_id_ex},   32'd0);
        check_eq("unhold_imm",   {16'd0, Imm_id_ex},     32'h1111);

        // Valid_id=0 on a normal load is not a bubble.
        clear_inputs();
        RegWrite_id = 1; Valid_id = 0; WriteReg_id = 3'd6;
        step();
        check_eq("inv_valid",   {31'd0, Valid_id_ex},    32'd0);
        check_eq("inv_regwr",   {31'd0, RegWrite_id_ex}, 32'd1);
        check_eq("inv_wreg",    {29'd0, WriteReg_id_ex}, 32'd6);
        check_eq("inv_state",   {30'd0, state},          32'd0);
        check_eq("inv_count",   {16'd0, bubbleCount},    32'd2);

        // Reset mid-hold, then hold after release keeps the zeros.
        clear_inputs();
        Imm_id = 16'hBEEF; Valid_id = 1; RegWrite_id = 1;
        step();
        hold = 1;
        step();
        check_eq("mh_imm",      {16'd0, Imm_id_ex},      32'hBEEF);
        rst_n = 1'b0;
        step();
        check_eq("mrst_imm",    {16'd0, Imm_id_ex},      32'd0);
        check_eq("mrst_valid",  {31'd0, Valid_id_ex},    32'd0);
        check_eq("mrst_regwr",  {31'd0, RegWrite_id_ex}, 32'd0);
        check_eq("mrst_count",  {16'd0, bubbleCount},    32'd0);
        check_eq("mrst_state",  {30'd0, state},          32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rhold_imm",   {16'd0, Imm_id_ex},      32'd0);
        check_eq("rhold_valid", {31'd0, Valid_id_ex},    32'd0);
        check_eq("rhold_state", {30'd0, state},          32'd3);

        // Reset mid-bubble clears the count; the first edge after release bubbles again.
        clear_inputs();
        controlZero = 1;
        step();
        check_eq("mb_count",    {16'd0, bubbleCount},    32'd1);
        rst_n = 1'b0;
        step();
        check_eq("mbrst_count", {16'd0, bubbleCount},    32'd0);
        check_eq("mbrst_state", {30'd0, state},          32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rel_count",   {16'd0, bubbleCount},    32'd1);
        check_eq("rel_state",   {30'd0, state},          32'd1);

        // Saturation: from reset, 65535 bubbles reach FFFF, one more stays there.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        controlZero = 1;
        repeat (65534) @(posedge clk);
        step();
        check_eq("sat_reach",   {16'd0, bubbleCount},    32'hFFFF);
        step();
        check_eq("sat_hold",    {16'd0, bubbleCount},    32'hFFFF);
        check_eq("sat_state",   {30'd0, state},          32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports clk input 1 (single clock, all state updates on rising edge) and rst_n input 1 (reset is synchronous and active-low).
REQ-002 SHALL have inputs from decode:
- RegWrite_id, MemRead_id, MemWrite_id, MemToReg_id, Halt_id: 1 bit each.
- ALUOp_id: 4 bits.
- PC2_id, RdData1_id, RdData2_id, Imm_id: 16 bits each.
- Rs_id, Rt_id, WriteReg_id: 3 bits each.
- RsValid_id, RtValid_id, Valid_id: 1 bit each.
REQ-003 SHALL have controlZero input 1: bubble request from load-use hazard detection.
REQ-004 SHALL have flush input 1: squash request on a taken branch/jump.
REQ-005 SHALL have hold input 1: downstream stall; the register keeps its contents.
REQ-006 SHALL have outputs named as the REQ-002 inputs with suffix _id_ex, same widths, driven directly from register state.
REQ-007 SHALL have bubbleCount output 16: saturating count of inserted bubbles.
REQ-008 SHALL have state output 2: current state encoding, for debug.

Function
REQ-009 SHALL select the per-cycle action by priority: rst_n low > flush > hold > controlZero > normal load.
REQ-010 Normal load: on the next edge, all *_id_ex outputs SHALL equal the *_id inputs; latency is exactly one cycle.
REQ-011 Bubble (controlZero=1, flush=0, hold=0) SHALL clear RegWrite, MemRead, MemWrite, MemToReg, Halt, RsValid, RtValid, Valid and ALUOp to 0.
REQ-012 During a bubble, PC2, RdData1, RdData2, Imm, Rs, Rt and WriteReg SHALL load normally; they are don't-care while Valid_id_ex=0.
REQ-013 Flush SHALL clear the same fields as a bubble and SHALL NOT increment bubbleCount.
REQ-014 Hold SHALL keep every output unchanged, including bubbleCount, even if controlZero=1.
REQ-015 bubbleCount SHALL increment by 1 on each bubble edge and saturate at 16'hFFFF without wrap.
REQ-016 The FSM SHALL have states RUN=2'b00, BUBBLE=2'b01, FLUSHED=2'b10, HELD=2'b11.
REQ-017 The next state SHALL be FLUSHED on flush, else HELD on hold, else BUBBLE on controlZero, else RUN.
REQ-018 state SHALL reflect the action taken at the most recent edge.
REQ-019 Because MemRead_id_ex is cleared in the cycle after a bubble, consecutive load-use bubbles from one load SHALL NOT occur; a second bubble SHALL be inserted only if controlZero is asserted again.
REQ-020 Simultaneous flush and controlZero SHALL act as flush only.
REQ-021 Simultaneous hold and controlZero SHALL act as hold only; the bubble is taken on the first non-hold cycle if controlZero is still asserted.
REQ-022 Valid_id=0 on a normal load SHALL propagate as Valid_id_ex=0 with the other fields loaded as given; it is not counted as a bubble.
REQ-023 No output SHALL combinationally depend on any input.

Reset
REQ-024 When rst_n=0 at an edge, all *_id_ex outputs SHALL become 0, bubbleCount 0 and state RUN, regardless of flush, hold or controlZero.
REQ-025 Reset asserted mid-hold or mid-bubble SHALL take effect at that same edge, with no residual state.
REQ-026 After rst_n returns high, the first edge SHALL perform the action selected by REQ-009.

Verification
REQ-027 Reset then load: rst_n=0 for 2 cycles, then PC2_id=16'h0010, RdData1_id=16'h1234, MemRead_id=1, Rt_id=3'd5, Valid_id=1 -> one edge later matching outputs, state=RUN, bubbleCount=0.
REQ-028 Load-use bubble: load in ID/EX, controlZero=1 for one cycle with RegWrite_id=1, Valid_id=1 -> RegWrite_id_ex=0, MemRead_id_ex=0, Valid_id_ex=0, state=BUBBLE, bubbleCount=1; next cycle controlZero=0 -> normal load, state=RUN.
REQ-029 Priority: flush=1 and controlZero=1 together -> Valid_id_ex=0, state=FLUSHED, bubbleCount unchanged; hold=1 and controlZero=1 for 3 cycles -> outputs frozen, state=HELD; then hold=0, controlZero=1 -> bubble, bubbleCount+1.
REQ-030 Saturation: bubbleCount preloaded via 65535 bubble cycles, one more bubble -> bubbleCount stays 16'hFFFF.
REQ-031 Reset mid-operation: hold=1 with stored data 16'hBEEF, then rst_n=0 for one edge -> all outputs 0, state=RUN; rst_n=1 with hold=1 -> outputs remain 0.
